// File: rtl/matrix_stamp_accumulator.sv
// Read-modify-write sequencer: stamps +/- float contributions into the matrix RAM through
// a RAM_LAT-cycle read, an ADD_LAT-cycle adder and a port-B write-back.
module matrix_stamp_accumulator #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned ADD_LAT = 7,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              program_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_sub,
  output logic              busy,
  output logic [CNT_W-1:0]  stamp_count,
  output logic [ADDR_W-1:0] matrix_addr_a,
  output logic [DATA_W-1:0] matrix_data_a,
  output logic              matrix_wren_a,
  input  logic [DATA_W-1:0] matrix_out_a,
  output logic [ADDR_W-1:0] matrix_addr_b,
  output logic [DATA_W-1:0] matrix_data_b,
  output logic              matrix_wren_b,
  output logic [DATA_W-1:0] adder_data_a,
  output logic [DATA_W-1:0] adder_data_b,
  input  logic [DATA_W-1:0] adder_out
);

  localparam int unsigned D = RAM_LAT + ADD_LAT;

  // Stage k holds the stamp accepted k+1 cycles ago.
  logic [D-1:0]      valid_q;
  logic [ADDR_W-1:0] addr_q [D];
  logic [DATA_W-1:0] op_q   [D];
  logic [ADDR_W-1:0] addr_a_q;
  logic [CNT_W-1:0]  count_q;

  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] operand;

  // A port-A read must not overtake any in-flight write to the same cell.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < int'(D); k++) begin
      if (valid_q[k] && (addr_q[k] == req_addr)) hazard = 1'b1;
    end
  end

  assign req_ready = !program_reset && !hazard;
  assign accept    = req_valid && req_ready;
  assign operand   = {req_data[DATA_W-1] ^ req_sub, req_data[DATA_W-2:0]};

  always_ff @(posedge clk) begin
    if (program_reset) begin
      valid_q  <= '0;
      addr_a_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < int'(D); k++) begin
        addr_q[k] <= '0;
        op_q[k]   <= '0;
      end
    end else begin
      valid_q   <= {valid_q[D-2:0], accept};
      addr_q[0] <= req_addr;
      op_q[0]   <= operand;
      for (int k = 1; k < int'(D); k++) begin
        addr_q[k] <= addr_q[k-1];
        op_q[k]   <= op_q[k-1];
      end
      if (accept) addr_a_q <= req_addr;
      if (valid_q[D-1]) count_q <= count_q + CNT_W'(1);
    end
  end

  assign matrix_addr_a = program_reset ? '0 : (accept ? req_addr : addr_a_q);
  assign matrix_data_a = '0;
  assign matrix_wren_a = 1'b0;

  assign adder_data_a = matrix_out_a;
  assign adder_data_b = op_q[RAM_LAT-1];

  assign matrix_wren_b = valid_q[D-1] && !program_reset;
  assign matrix_addr_b = program_reset ? '0 : addr_q[D-1];
  assign matrix_data_b = adder_out;

  assign busy        = (|valid_q) && !program_reset;
  assign stamp_count = count_q;

endmodule

// File: tb/tb_matrix_stamp_accumulator.sv
// Bench for matrix_stamp_accumulator: behavioural RAM and adder around the DUT, checked against
// an integer-valued accumulation model with a pending-write queue.
module tb_matrix_stamp_accumulator;

  localparam int D = 9;

  logic        clk = 1'b0;
  logic        program_reset;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic        req_sub;
  logic        busy;
  logic [15:0] stamp_count;
  logic [11:0] matrix_addr_a;
  logic [31:0] matrix_data_a;
  logic        matrix_wren_a;
  logic [31:0] matrix_out_a;
  logic [11:0] matrix_addr_b;
  logic [31:0] matrix_data_b;
  logic        matrix_wren_b;
  logic [31:0] adder_data_a;
  logic [31:0] adder_data_b;
  logic [31:0] adder_out;

  matrix_stamp_accumulator dut (
    .clk           (clk),
    .program_reset (program_reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_sub       (req_sub),
    .busy          (busy),
    .stamp_count   (stamp_count),
    .matrix_addr_a (matrix_addr_a),
    .matrix_data_a (matrix_data_a),
    .matrix_wren_a (matrix_wren_a),
    .matrix_out_a  (matrix_out_a),
    .matrix_addr_b (matrix_addr_b),
    .matrix_data_b (matrix_data_b),
    .matrix_wren_b (matrix_wren_b),
    .adder_data_a  (adder_data_a),
    .adder_data_b  (adder_data_b),
    .adder_out     (adder_out)
  );

  always #5 clk = ~clk;

  // Float helpers, exact for integer values below 2^23.
  function automatic int f2i(logic [31:0] f);
    int e;
    int m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0) return 0;
    m = int'({9'd1, f[22:0]}) >> (23 - e);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] i2f(int v);
    logic [31:0] r;
    int mag;
    int e;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? -v : v;
    e = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) e = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'((mag << (23 - e)) & 32'h007F_FFFF);
    return r;
  endfunction

  // Environment: matrix RAM (2-cycle read, old data on collision) and 7-stage adder.
  logic [31:0] mem [4096];
  logic [31:0] rd1, rd2;
  logic [31:0] apipe [7];
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [31:0] poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (matrix_wren_b) mem[matrix_addr_b] <= matrix_data_b;
    rd1 <= mem[matrix_addr_a];
    rd2 <= rd1;
    apipe[0] <= i2f(f2i(adder_data_a) + f2i(adder_data_b));
    for (int i = 1; i < 7; i++) apipe[i] <= apipe[i-1];
  end
  assign matrix_out_a = rd2;
  assign adder_out    = apipe[6];

  // Reference model: cell values as integers, stamps awaiting write-back in order.
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] op;
    int          acc;
  } pend_t;
  pend_t       pend [$];
  int          ref_v [4096];
  logic [15:0] cnt_model = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        last_acc = 1'b0;
  int          acc_cyc = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic  exp_ready;
    logic  acc;
    logic  wr_exp;
    pend_t p;
    int    delta;
    @(negedge clk);
    exp_ready = !program_reset;
    foreach (pend[i]) if (pend[i].addr == req_addr) exp_ready = 1'b0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(!program_reset && pend.size() > 0));
    acc = req_valid && exp_ready;
    if (program_reset) begin
      chk("addr_a_reset", 32'(matrix_addr_a), 32'd0);
      chk("addr_b_reset", 32'(matrix_addr_b), 32'd0);
    end else if (acc) begin
      chk("addr_a", 32'(matrix_addr_a), 32'(req_addr));
    end
    wr_exp = 1'b0;
    if (!program_reset && pend.size() > 0) wr_exp = (pend[0].acc + D == cyc);
    chk("wren_b", 32'(matrix_wren_b), 32'(wr_exp));
    if (wr_exp && matrix_wren_b) begin
      chk("addr_b", 32'(matrix_addr_b), 32'(pend[0].addr));
      chk("data_b", matrix_data_b, pend[0].data);
    end
    if (!program_reset) chk("stamp_count", 32'(stamp_count), 32'(cnt_model));
    foreach (pend[i]) if (pend[i].acc + 2 == cyc) chk("adder_b", adder_data_b, pend[i].op);
    if (wr_exp) begin
      void'(pend.pop_front());
      cnt_model++;
    end
    if (program_reset) begin
      // Dropped stamps never reach the RAM, so those cells keep their stored value.
      foreach (pend[i]) ref_v[pend[i].addr] = f2i(mem[pend[i].addr]);
      pend.delete();
      cnt_model = '0;
    end
    if (acc) begin
      delta = req_sub ? -f2i(req_data) : f2i(req_data);
      ref_v[req_addr] += delta;
      p.addr = req_addr;
      p.data = i2f(ref_v[req_addr]);
      p.op   = {req_data[31] ^ req_sub, req_data[30:0]};
      p.acc  = cyc;
      pend.push_back(p);
      acc_cyc = cyc;
    end
    last_acc = acc;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic poke(logic [11:0] a, int v);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = i2f(v);
    ref_v[a] = v;
    cycle();
    poke_en = 1'b0;
  endtask

  task automatic stamp(logic [11:0] a, int v, logic s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = i2f(v);
    req_sub   = s;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 32'(last_acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (pend.size() == 0) break;
      cycle();
    end
    if (pend.size() != 0) chk("drain_timeout", 32'(pend.size()), 32'd0);
    cycle();
  endtask

  initial begin
    int a1, a2, a3, prev;
    program_reset = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_sub   = 1'b0;
    cycle();
    cycle();
    program_reset = 1'b0;
    cycle();

    // Single add: 1.0 + 2.0.
    poke(12'h041, 1);
    stamp(12'h041, 2, 1'b0);
    drain();

    // Single subtract: 1.0 - 2.0.
    poke(12'h000, 1);
    stamp(12'h000, 2, 1'b1);
    drain();

    // Same-address chain, successors accepted D+1 cycles apart.
    poke(12'h7FF, 0);
    stamp(12'h7FF, 1, 1'b0); a1 = acc_cyc;
    stamp(12'h7FF, 1, 1'b0); a2 = acc_cyc;
    stamp(12'h7FF, 1, 1'b0); a3 = acc_cyc;
    chk("chain_gap1", 32'(a2 - a1), 32'd10);
    chk("chain_gap2", 32'(a3 - a2), 32'd10);
    drain();

    // Distinct-address burst, one accept per cycle.
    for (int i = 0; i < 16; i++) poke(12'h100 + 12'(i), int'($urandom_range(200)) - 100);
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      stamp(12'h100 + 12'(i), 1, 1'b0);
      if (i > 0) chk("burst_b2b", 32'(acc_cyc - prev), 32'd1);
      prev = acc_cyc;
    end
    drain();

    // Mixed hazard: third stamp waits for the first write-back.
    poke(12'h010, 5);
    poke(12'h011, 7);
    stamp(12'h010, 1, 1'b0); a1 = acc_cyc;
    stamp(12'h011, 1, 1'b0);
    stamp(12'h010, 1, 1'b0); a3 = acc_cyc;
    chk("mixed_gap", 32'(a3 - a1), 32'd10);
    drain();

    // Reset mid-flight: stamp dropped, counter cleared, then a normal stamp.
    stamp(12'h041, 4, 1'b0);
    cycle();
    cycle();
    cycle();
    program_reset = 1'b1;
    cycle();
    program_reset = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    stamp(12'h041, 2, 1'b0);
    drain();

    // Random stamps over a small address set to provoke hazards.
    for (int i = 0; i < 16; i++) poke(12'(i), int'($urandom_range(1000)) - 500);
    for (int i = 0; i < 300; i++) begin
      stamp(12'($urandom_range(15)), int'($urandom_range(1000)), 1'($urandom_range(1)));
      for (int g = int'($urandom_range(2)); g > 0; g--) cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_stamp_accumulator.md
Name: matrix_stamp_accumulator

Overview:
- Read-modify-write sequencer that "stamps" float contributions into the float_matrix RAM (4096x32; row/col packed into a 12-bit address).
- Owns matrix port A for reads, port B for writes, and one pipelined float adder.
- Accepts a stream of stamp requests, each meaning "matrix[addr] += value" or "matrix[addr] -= value".
- Detects read-after-write hazards on in-flight addresses and stalls only those requests.
- Sits between the equation-generation controller and the shared matrix/adder resources.

Parameters:
- ADDR_W, 12, matrix address width.
- DATA_W, 32, IEEE-754 single word width.
- RAM_LAT, 2, cycles from matrix_addr_a presented to matrix_out_a valid.
- ADD_LAT, 7, adder latency: dataa/datab to result.
- CNT_W, 16, width of the completed-stamp counter.

Ports:
- clk  in  1  system clock
- program_reset  in  1  synchronous, active-high reset
- req_valid  in  1  stamp request present
- req_ready  out  1  stamp accepted this cycle when req_valid is also high
- req_addr  in  ADDR_W  target matrix cell
- req_data  in  DATA_W  float operand
- req_sub  in  1  1 = subtract operand, 0 = add
- busy  out  1  any stamp in flight
- stamp_count  out  CNT_W  completed write-backs, wraps modulo 2^CNT_W
- matrix_addr_a  out  ADDR_W  read address
- matrix_data_a  out  DATA_W  tied 0
- matrix_wren_a  out  1  tied 0
- matrix_out_a  in  DATA_W  read data
- matrix_addr_b  out  ADDR_W  write address
- matrix_data_b  out  DATA_W  write data
- matrix_wren_b  out  1  write enable
- adder_data_a  out  DATA_W  adder operand (old cell value)
- adder_data_b  out  DATA_W  adder operand (signed stamp value)
- adder_out  in  DATA_W  adder result

Behaviour:
- Clock and reset: single clock clk; program_reset is synchronous, active-high. While program_reset is high:
  - pipeline valid bits, address and operand shift registers, and stamp_count clear to 0;
  - req_ready = 0, busy = 0, matrix_wren_b = 0, matrix_addr_a/b = 0.
- Pipeline depth: D = RAM_LAT + ADD_LAT (9 by default).
- Accept: a stamp is accepted in cycle c0 when req_valid & req_ready.
- Cycle c0:
  - matrix_addr_a = req_addr, driven combinationally while accepting; otherwise it holds its last value.
  - Operand = req_data with bit 31 XORed with req_sub. Subtract is done by sign flip; no subtractor is used.
  - Operand and address enter a D-deep shift register.
- Cycle c0+RAM_LAT:
  - adder_data_a = matrix_out_a;
  - adder_data_b = the delayed operand.
  - Adder inputs are don't-care when no valid stamp is in this stage.
- Cycle c0+D:
  - matrix_wren_b = 1, matrix_addr_b = delayed address, matrix_data_b = adder_out.
  - stamp_count increments at the end of this cycle.
- Throughput: one stamp per cycle for distinct addresses.
- Hazard rule:
  - Port-B writes are visible to a port-A read only one cycle after the write cycle; mixed-port read-during-write returns old data.
  - req_ready = 0 if req_addr equals the address of any valid stamp accepted in cycles c-D..c-1. Otherwise req_ready = 1.
  - A same-address successor is therefore accepted no earlier than c0+D+1.
  - req_ready depends combinationally on req_addr. The requester must hold req_valid, req_addr, req_data and req_sub stable until accepted.
- busy = OR of all pipeline valid bits. busy is 0 in the cycle after the last write-back.
- Simultaneous write-back and accept of different addresses: both proceed in the same cycle.
- Reset mid-operation: all in-flight stamps are dropped and no write is issued from the next cycle on. Matrix contents for dropped cells are undefined; the sequencing controller must reinitialise the matrix.
- stamp_count wraps from 0xFFFF to 0x0000.
- No floating-point exception handling; NaN/Inf propagate through the adder unchanged.

Test Plan:
- Single add:
  - Stimulus: cell 0x041 = 0x3F800000 (1.0); stamp 0x40000000 (2.0), req_sub = 0, accepted at c0.
  - Response: matrix_wren_b high only at c0+9, addr 0x041, data 0x40400000 (3.0); stamp_count = 1; busy high from c0+1 through c0+9.
- Single subtract:
  - Stimulus: cell 0x000 = 1.0; stamp 2.0 with req_sub = 1.
  - Response: adder_data_b = 0xC0000000; write data 0xBF800000 (-1.0) at c0+9.
- Same-address chain:
  - Stimulus: three stamps of 1.0 to cell 0x7FF (initially 0), req_valid held high.
  - Response: accepts at c0, c0+10, c0+20; req_ready low in between; final write at c0+29 = 0x40400000; stamp_count = 3.
- Distinct-address burst:
  - Stimulus: 16 stamps of 1.0 to addresses 0x100..0x10F, one per cycle.
  - Response: req_ready constantly 1; 16 consecutive write cycles c0+9..c0+24, each storing cell+1.0; stamp_count = 16.
- Mixed hazard:
  - Stimulus: addresses 0x010, 0x011, 0x010 on consecutive cycles.
  - Response: third stamp stalls until c0+10; writes at c0+9, c0+10, c0+19; cell 0x010 receives both increments.
- Reset mid-flight:
  - Stimulus: assert program_reset at c0+4 for 1 cycle after a stamp at c0.
  - Response: no matrix_wren_b for 9 cycles after reset; busy = 0 and stamp_count = 0 from the cycle after reset; next stamp behaves as in the single-add case.
